// File: rtl/rv32_alu_pkg.sv
// Shared types for the chunked RV32 execute ALU: data width, opcode and FSM state encodings.
package rv32_alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } alu_exec_state_e;

endpackage

// File: rtl/rv32_alu_chunk.sv
// Combinational CHUNK_W-bit ALU slice with ripple carry in/out.
// With RV32_ALU_OVERFLOW_EN, also exposes the carry into the slice MSB.
module rv32_alu_chunk
    import rv32_alu_pkg::*;
#(
    parameter int CHUNK_W = 8
) (
    input  alu_op_e              i_op,
    input  logic [CHUNK_W-1:0]   i_a,
    input  logic [CHUNK_W-1:0]   i_b,
    input  logic                 i_cin,
    output logic [CHUNK_W-1:0]   o_result,
    output logic                 o_cout
`ifdef RV32_ALU_OVERFLOW_EN
    ,
    output logic                 o_c_msb
`endif
);

    logic               w_arith;
    logic [CHUNK_W-1:0] w_b;
    logic [CHUNK_W:0]   w_sum;

    // Slice arithmetic: SUB adds ~B, the caller seeds carry=1 for the +1.
    // Logic ops pass the carry through untouched.
    always_comb begin
        w_arith = (i_op == ALU_ADD) || (i_op == ALU_SUB);
        w_b     = (i_op == ALU_SUB) ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b} + {{CHUNK_W{1'b0}}, i_cin};
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            default: o_result = w_sum[CHUNK_W-1:0];
        endcase
        o_cout = w_arith ? w_sum[CHUNK_W] : i_cin;
`ifdef RV32_ALU_OVERFLOW_EN
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
        o_c_msb = w_arith ? (w_sum[CHUNK_W-1] ^ i_a[CHUNK_W-1] ^ w_b[CHUNK_W-1]) : 1'b0;
`endif
    end

endmodule

// File: rtl/rv32_alu_chunk_exec.sv
// Multicycle RV32 ALU: one CHUNK_W slice per clock, LSB first, start/busy in,
// valid/ack out. Optional signed-overflow output under RV32_ALU_OVERFLOW_EN.
module rv32_alu_chunk_exec
    import rv32_alu_pkg::*;
#(
    parameter int CHUNK_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_operand_one,
    input  logic [XLEN-1:0] i_operand_two,
    input  logic [1:0]      i_alu_sel,
    input  logic            i_ack,
    output logic            o_busy,
    output logic            o_data_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_carry_out
`ifdef RV32_ALU_OVERFLOW_EN
    ,
    output logic            o_overflow
`endif
);

    localparam int N     = XLEN / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    alu_exec_state_e    r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_a, r_b, r_res;
    alu_op_e            r_op;
    logic               r_carry;
    logic [CHUNK_W-1:0] w_a_sl, w_b_sl, w_sl_res;
    logic               w_cout;
    logic               w_last;
`ifdef RV32_ALU_OVERFLOW_EN
    logic               r_ovf;
    logic               w_c_msb;
`endif

    assign w_last = (r_cnt == CNT_W'(N - 1));

    // Select the operand slices addressed by the chunk counter.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_sl = r_a[k*CHUNK_W +: CHUNK_W];
                w_b_sl = r_b[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    rv32_alu_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .i_op     (r_op),
        .i_a      (w_a_sl),
        .i_b      (w_b_sl),
        .i_cin    (r_carry),
        .o_result (w_sl_res),
        .o_cout   (w_cout)
`ifdef RV32_ALU_OVERFLOW_EN
        ,
        .o_c_msb  (w_c_msb)
`endif
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: start only matters in IDLE, ack only in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = EXEC;
            EXEC:    if (w_last)  w_state_nxt = DONE;
            DONE:    if (i_ack)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture at accept, then fold one slice per EXEC cycle into the result.
    // Result/carry are not cleared on return to IDLE so they stay readable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= ALU_ADD;
            r_res   <= '0;
            r_carry <= 1'b0;
`ifdef RV32_ALU_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else if (r_state == IDLE && i_start) begin
            r_cnt   <= '0;
            r_a     <= i_operand_one;
            r_b     <= i_operand_two;
            r_op    <= alu_op_e'(i_alu_sel);
            r_carry <= (alu_op_e'(i_alu_sel) == ALU_SUB);
`ifdef RV32_ALU_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else if (r_state == EXEC) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_cout;
            for (int k = 0; k < N; k++) begin
                if (r_cnt == CNT_W'(k)) r_res[k*CHUNK_W +: CHUNK_W] <= w_sl_res;
            end
`ifdef RV32_ALU_OVERFLOW_EN
            if (w_last) r_ovf <= w_c_msb ^ w_cout;
`endif
        end
    end

    assign o_busy       = (r_state != IDLE);
    assign o_data_valid = (r_state == DONE);
    assign o_result     = r_res;
    assign o_carry_out  = r_carry;
`ifdef RV32_ALU_OVERFLOW_EN
    assign o_overflow   = r_ovf;
`endif

endmodule

// File: doc/rv32_alu_chunk_exec.md
# rv32_alu_chunk_exec

Multicycle RV32 execute-stage ALU that processes one CHUNK_W-bit slice of the operands per clock, LSB slice first. Operands and opcode are accepted through a start/busy handshake, and the result is held with o_data_valid until the requester acknowledges it. The block is the responder side of the execute-FSM handshake. Decode/control, and the execute-stage bench, drive operands and wait for valid with a bounded timeout.

## Interface
- CHUNK_W, 8, bits processed per cycle; legal values are 1, 2, 4, 8, 16, 32; latency N = 32/CHUNK_W
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_operand_one  input  32  operand A, captured at accept
- i_operand_two  input  32  operand B, captured at accept
- i_alu_sel  input  2  op: 00 ADD, 01 SUB, 10 AND, 11 OR; captured at accept
- i_ack  input  1  result consumed; sampled only in DONE
- o_busy  output  1  high in EXEC and DONE
- o_data_valid  output  1  high only in DONE
- o_result  output  32  result; meaningful while o_data_valid is high
- o_carry_out  output  1  final carry for ADD/SUB; 0 for AND/OR
- o_overflow  output  1  signed overflow; present only with RV32_ALU_OVERFLOW_EN

## Operation
- States: IDLE, EXEC, DONE.
- IDLE -> EXEC: on an edge with i_start=1.
  - Latch A, B and op.
  - Clear the chunk counter.
  - Carry register = 1 for SUB, 0 otherwise.
- EXEC: each edge computes slice k = counter.
  - ADD: A[k] + B[k] + c.
  - SUB: A[k] + ~B[k] + c.
  - AND/OR: bitwise, carry unchanged (the registered carry is cleared at accept for AND/OR).
  - The slice is written into the result register; the carry register takes the slice carry.
  - The counter increments.
- EXEC -> DONE: on the edge that processes slice N-1.
- DONE -> IDLE: on an edge with i_ack=1.
- SUB carry semantics: o_carry_out=1 means no borrow (A >= B unsigned).
- i_start is ignored in EXEC and DONE; there is no queueing.
- i_start and i_ack both high in DONE: return to IDLE; the start is dropped and must be re-presented in IDLE.
- o_result and o_carry_out retain their values after IDLE is re-entered, until the next accept.
- Operand and op inputs may change freely after the accept edge.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0.
  - o_busy=0, o_data_valid=0, o_result=0, o_carry_out=0, o_overflow=0.
- Reset during EXEC or DONE aborts the operation immediately; no valid pulse is produced.
- Accept edge E0 -> o_busy=1 after E0.
- o_data_valid rises after edge E_N: N cycles after accept, 4 at the default.
- The execute bench allows 8 cycles, so CHUNK_W >= 4 is required there.
- o_data_valid is held until the ack edge and falls after it.
- Earliest next accept is the edge after the ack edge. Throughput is N+2 cycles per operation with zero-wait ack.
- CHUNK_W=32: single EXEC cycle; valid follows the cycle after accept.

## Configuration
- Macro: RV32_ALU_OVERFLOW_EN.
- Defined:
  - Port o_overflow exists.
  - For ADD/SUB it is set at the DONE transition to (carry into bit 31) XOR (carry out of bit 31).
  - It is 0 for AND/OR.
  - It is held and reset exactly like o_carry_out.
- Undefined: the port and its logic are absent; everything else is identical.

## Structure
- Package rv32_alu_pkg holds:
  - XLEN=32.
  - alu_op_e enum: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, 2-bit.
  - alu_exec_state_e enum: IDLE, EXEC, DONE.
- Sub-module rv32_alu_chunk: combinational CHUNK_W slice.
  - Inputs: op, a, b, cin.
  - Outputs: result, cout, and the bit-31 carry-in used for overflow.
- Top level: FSM, counter, operand/result registers, chunk select/insert.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry 1; valid exactly 4 cycles after the accept edge.
- SUB 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry 0. SUB 7 - 5 -> result 0x00000002, carry 1.
- AND 0xF0F0A5A5, 0x0FF0FF00 -> 0x00F0A500; OR of the same operands -> 0xFFF0FFA5; carry 0 for both.
- i_start pulsed during EXEC with different operands -> ignored; the first result is unchanged.
  - Ack held low for 10 cycles -> valid and result stable throughout.
  - Ack and start together in DONE -> IDLE, no new op.
- i_rst_n low for one cycle during the third EXEC cycle -> all outputs 0 immediately; no valid pulse. The next op completes normally.
- With RV32_ALU_OVERFLOW_EN: ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow 1, carry 0. SUB 0x80000000 - 1 -> overflow 1.
